vlc_rx_frame_ctrl: RTL and testbench
====================================

// Module: vlc_rx_frame_ctrl
// PURPOSE
//  Receive-side frame sequencer for the VLC serial link; sits between the photodetector
//  bit slicer and the 32-bit word consumer. Hunts for a 32-bit sync word, checks a
//  length header and packs payload bits LSB-first into 32-bit words. Delivers words
//  through an internal FIFO with a valid/ready handshake and SOF/EOF markers.
// PARAMETERS
//  SYNC_WORD   32'hD3917A5C  frame sync pattern, compared LSB-first (first bit = bit 0)
//  MAX_WORDS   255           largest accepted payload length in words (1..65535)
//  FIFO_DEPTH  8             output FIFO entries; power of 2, >= 2
// PORTS
//  iClk        in   1   clock
//  iReset_n    in   1   synchronous, active-low reset
//  iEnable     in   1   1 = receive; 0 = abort/idle
//  iBitValid   in   1   iData is a new line bit this cycle
//  iData       in   1   serial line bit
//  oData       out  32  FIFO head word
//  oSof        out  1   head word is first payload word of a frame
//  oEof        out  1   head word is last payload word of a frame
//  oValid      out  1   FIFO not empty
//  iReady      in   1   consumer accepts head word when oValid&&iReady
//  oLen        out  16  length of last accepted header
//  oBusy       out  1   state is HEADER or PAYLOAD
//  oFrameErr   out  1   1-cycle pulse: bad header or frame aborted
//  oOverflow   out  1   1-cycle pulse: word dropped, FIFO full
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, oValid=0, oData=0, oSof=oEof=0, oLen=0, oBusy=0,
//   oFrameErr=oOverflow=0, shift reg and bit/word counters 0.
//  Bits are consumed only on cycles with iBitValid=1. Shift: sr <= {iData, sr[31:1]}.
//  States:
//   IDLE:    iEnable=1 -> HUNT; clear sr and hunt counter.
//   HUNT:    shift each bit. When >=32 bits shifted since entry and sr == SYNC_WORD
//            (post-shift) -> HEADER, bit counter = 0. Overlapping sync matches allowed.
//   HEADER:  collect 32 bits. On 32nd bit: valid iff hdr[31:16] == ~hdr[15:0] and
//            1 <= hdr[15:0] <= MAX_WORDS. Valid: oLen <= hdr[15:0], word count = 0 ->
//            PAYLOAD. Invalid: oFrameErr pulse, -> HUNT (sr cleared, hunt count 0).
//   PAYLOAD: collect 32 bits per word; on 32nd bit push {sof,eof,word}: sof = (word
//            count==0), eof = (word count==oLen-1). After the eof push -> HUNT.
//  Word timing: the edge sampling bit 32 writes the FIFO; oValid=1 from the next cycle
//   when FIFO was empty. oData/oSof/oEof are show-ahead from the head entry (0 when empty).
//  FIFO: pop when oValid&&iReady. Push accepted if count<FIFO_DEPTH or a pop occurs
//   in the same cycle; simultaneous push+pop keeps count unchanged.
//  Overflow: push when full without pop -> word dropped, oOverflow pulse, oFrameErr
//   pulse, rest of frame abandoned, -> HUNT. Words already queued are kept.
//  iEnable=0 in any state -> IDLE next cycle, partial word discarded. If state was
//   HEADER or PAYLOAD, oFrameErr pulses. FIFO contents retained and drainable.
//  iReset_n=0 mid-frame: everything returns to reset values, including FIFO contents.
//  oBusy registered: 1 in HEADER/PAYLOAD cycles.
// TESTING
//  1 Sync, hdr 32'hFFFC0003, 3 words 11111111/22222222/33333333 with iReady=1 -> 3 pops;
//    oSof on word 1 only, oEof on word 3 only, oLen=3, back to HUNT.
//  2 Sync, hdr 32'h12340003 (bad complement) -> oFrameErr pulse, no FIFO writes;
//    next good frame is received normally.
//  3 Hdr length 0 or MAX_WORDS+1 -> oFrameErr, no writes; length MAX_WORDS accepted.
//  4 iReady=0, 10-word frame, FIFO_DEPTH=8 -> 8 words queued, oOverflow+oFrameErr
//    on word 9; draining yields 8 words, none with oEof.
//  5 iEnable dropped after 2 payload words -> oFrameErr, IDLE; 2 words still drain.
//  6 Random iBitValid gaps plus a false partial-sync prefix -> words bit-exact vs model.

Source files
------------

// File: rtl/vlc_rx_frame_ctrl.sv
// vlc_rx_frame_ctrl
//   Receive-side frame sequencer for the VLC serial link. It hunts for a 32-bit
//   sync word in the sliced line bits and checks the length header that follows.
//   It then packs the payload LSB-first into 32-bit words. Words leave through a
//   show-ahead FIFO with a valid/ready handshake, tagged with SOF/EOF markers.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | receiver disabled, waiting for iEnable
//   S_HUNT    | shifting line bits, looking for SYNC_WORD
//   S_HEADER  | collecting the 32-bit length header
//   S_PAYLOAD | collecting payload words and pushing them to the FIFO
//
// Ports
//   iClk, iReset_n   clock, synchronous active-low reset
//   iEnable          1 = receive, 0 = abort and idle
//   iBitValid, iData serial line bit strobe and value
//   oData/oSof/oEof  FIFO head word and its frame markers (0 when empty)
//   oValid, iReady   FIFO handshake; pop on oValid && iReady
//   oLen             length of the last accepted header
//   oBusy            1 while in S_HEADER / S_PAYLOAD
//   oFrameErr        1-cycle pulse on bad header or aborted frame
//   oOverflow        1-cycle pulse when a payload word was dropped (FIFO full)
module vlc_rx_frame_ctrl #(
  parameter logic [31:0] SYNC_WORD  = 32'hD3917A5C,
  parameter int          MAX_WORDS  = 255,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iEnable,
  input  logic        iBitValid,
  input  logic        iData,
  output logic [31:0] oData,
  output logic        oSof,
  output logic        oEof,
  output logic        oValid,
  input  logic        iReady,
  output logic [15:0] oLen,
  output logic        oBusy,
  output logic        oFrameErr,
  output logic        oOverflow
);

  localparam int           AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]  MAX_LEN = 16'(MAX_WORDS);
  localparam logic [5:0]   HUNT_LD = 6'd32;

  typedef enum logic [1:0] {S_IDLE, S_HUNT, S_HEADER, S_PAYLOAD} state_t;

  state_t      state;
  logic [31:0] sr;
  logic [31:0] sr_nxt;
  logic [5:0]  hunt_left;  // bits still needed before a sync match may count
  logic [4:0]  bit_left;   // bits remaining in the current header/payload word
  logic [15:0] word_cnt;

  logic [33:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fifo_cnt;

  logic pop;
  logic word_done;
  logic push_ok;
  logic is_sof;
  logic is_eof;
  logic hdr_ok;

  assign sr_nxt    = {iData, sr[31:1]};
  assign pop       = (fifo_cnt != '0) && iReady;
  assign word_done = iEnable && iBitValid && (state == S_PAYLOAD) && (bit_left == 5'd0);
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign push_ok   = word_done && ((fifo_cnt < DEPTH_C) || pop);
  assign is_sof    = (word_cnt == 16'd0);
  assign is_eof    = (word_cnt == oLen - 16'd1);
  assign hdr_ok    = (sr_nxt[31:16] == ~sr_nxt[15:0]) && (sr_nxt[15:0] != 16'd0) &&
                     (sr_nxt[15:0] <= MAX_LEN);

  assign oValid = (fifo_cnt != '0);
  assign oData  = oValid ? fifo_mem[rd_ptr][31:0] : 32'd0;
  assign oEof   = oValid ? fifo_mem[rd_ptr][32]   : 1'b0;
  assign oSof   = oValid ? fifo_mem[rd_ptr][33]   : 1'b0;

  always_ff @(posedge iClk) begin
    if (push_ok) fifo_mem[wr_ptr] <= {is_sof, is_eof, sr_nxt};
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state     <= S_IDLE;
      sr        <= '0;
      hunt_left <= '0;
      bit_left  <= '0;
      word_cnt  <= '0;
      oLen      <= '0;
      oBusy     <= 1'b0;
      oFrameErr <= 1'b0;
      oOverflow <= 1'b0;
    end else begin
      oFrameErr <= 1'b0;
      oOverflow <= 1'b0;
      if (!iEnable) begin
        state    <= S_IDLE;
        oBusy    <= 1'b0;
        bit_left <= '0;
        if (state == S_HEADER || state == S_PAYLOAD) oFrameErr <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_HUNT;
            sr        <= '0;
            hunt_left <= HUNT_LD;
          end
          S_HUNT: begin
            if (iBitValid) begin
              sr <= sr_nxt;
              if (hunt_left != 6'd0) hunt_left <= hunt_left - 6'd1;
              // hunt_left <= 1 means this bit is at least the 32nd since entry
              if (hunt_left <= 6'd1 && sr_nxt == SYNC_WORD) begin
                state    <= S_HEADER;
                bit_left <= 5'd31;
                oBusy    <= 1'b1;
              end
            end
          end
          S_HEADER: begin
            if (iBitValid) begin
              sr <= sr_nxt;
              if (bit_left != 5'd0) begin
                bit_left <= bit_left - 5'd1;
              end else if (hdr_ok) begin
                oLen     <= sr_nxt[15:0];
                word_cnt <= '0;
                bit_left <= 5'd31;
                state    <= S_PAYLOAD;
              end else begin
                oFrameErr <= 1'b1;
                state     <= S_HUNT;
                sr        <= '0;
                hunt_left <= HUNT_LD;
                oBusy     <= 1'b0;
              end
            end
          end
          S_PAYLOAD: begin
            if (iBitValid) begin
              sr <= sr_nxt;
              if (bit_left != 5'd0) begin
                bit_left <= bit_left - 5'd1;
              end else if (!push_ok || is_eof) begin
                // Either the frame completed or a word was lost; in both
                // cases the rest of the frame is not worth keeping.
                if (!push_ok) begin
                  oOverflow <= 1'b1;
                  oFrameErr <= 1'b1;
                end
                state     <= S_HUNT;
                sr        <= '0;
                hunt_left <= HUNT_LD;
                oBusy     <= 1'b0;
              end else begin
                word_cnt <= word_cnt + 16'd1;
                bit_left <= 5'd31;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vlc_rx_frame_ctrl.sv
module tb_vlc_rx_frame_ctrl;

  localparam logic [31:0] SYNC = 32'hD3917A5C;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        iEnable;
  logic        iBitValid;
  logic        iData;
  logic        iReady;
  logic [31:0] oData;
  logic        oSof;
  logic        oEof;
  logic        oValid;
  logic [15:0] oLen;
  logic        oBusy;
  logic        oFrameErr;
  logic        oOverflow;

  vlc_rx_frame_ctrl dut (
    .iClk(iClk), .iReset_n(iReset_n), .iEnable(iEnable), .iBitValid(iBitValid),
    .iData(iData), .oData(oData), .oSof(oSof), .oEof(oEof), .oValid(oValid),
    .iReady(iReady), .oLen(oLen), .oBusy(oBusy), .oFrameErr(oFrameErr),
    .oOverflow(oOverflow)
  );

  always #5 iClk = ~iClk;

  logic [33:0] sb[$];
  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int ovf_cnt  = 0;
  int exp_err  = 0;

  // Monitor: pops the scoreboard on every handshake the DUT presents.
  always @(negedge iClk) begin
    logic [33:0] exp_w;
    if (iReset_n) begin
      if (oFrameErr) err_cnt++;
      if (oOverflow) ovf_cnt++;
      if (oValid && iReady) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got sof=%0b eof=%0b data=%h, expected no word",
                   oSof, oEof, oData);
        end else begin
          exp_w = sb.pop_front();
          if ({oSof, oEof, oData} !== exp_w) begin
            failures++;
            $display("FAIL pop_word got sof=%0b eof=%0b data=%h, expected sof=%0b eof=%0b data=%h",
                     oSof, oEof, oData, exp_w[33], exp_w[32], exp_w[31:0]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 32; i++) begin
      iBitValid = 1'b0;
      repeat ($urandom_range(0, gap_max)) cyc(1);
      iBitValid = 1'b1;
      iData     = w[i];
      cyc(1);
    end
    iBitValid = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      iBitValid = 1'b1;
      iData     = w[i];
      cyc(1);
    end
    iBitValid = 1'b0;
  endtask

  task automatic restart();
    iEnable = 1'b0;
    cyc(1);
    iEnable = 1'b1;
    cyc(1);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || oValid) && n < 3000) begin
      cyc(1);
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  function automatic logic [31:0] pat(input int f, input int i);
    return 32'hA5000000 ^ (32'(f) << 16) ^ (32'(i) * 32'h00010203);
  endfunction

  initial begin
    logic [31:0] w;
    iReset_n = 1'b0; iEnable = 1'b0; iBitValid = 1'b0; iData = 1'b0; iReady = 1'b0;
    cyc(3);
    chk("rst_valid", 64'(oValid), 64'd0);
    chk("rst_data", 64'(oData), 64'd0);
    chk("rst_sofeof", 64'({oSof, oEof}), 64'd0);
    chk("rst_len", 64'(oLen), 64'd0);
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_pulses", 64'({oFrameErr, oOverflow}), 64'd0);
    iReset_n = 1'b1;
    cyc(2);

    // Test 1: basic 3-word frame, consumer always ready
    iReady = 1'b1;
    iEnable = 1'b1;
    cyc(1);
    send_word(SYNC, 0);
    chk("t1_busy_hdr", 64'(oBusy), 64'd1);
    send_word(32'hFFFC0003, 0);
    sb.push_back({1'b1, 1'b0, 32'h11111111});
    send_word(32'h11111111, 0);
    sb.push_back({1'b0, 1'b0, 32'h22222222});
    send_word(32'h22222222, 0);
    sb.push_back({1'b0, 1'b1, 32'h33333333});
    send_word(32'h33333333, 0);
    chk("t1_busy_end", 64'(oBusy), 64'd0);
    wait_drain("t1_drain");
    chk("t1_len", 64'(oLen), 64'd3);
    chk("t1_err", 64'(err_cnt), 64'(exp_err));

    // Test 2: bad complement header, then a good 1-word frame
    restart();
    send_word(SYNC, 0);
    send_word(32'h12340003, 0);
    exp_err++;
    cyc(3);
    chk("t2_err", 64'(err_cnt), 64'(exp_err));
    chk("t2_busy", 64'(oBusy), 64'd0);
    chk("t2_nowrite", 64'(oValid), 64'd0);
    send_word(SYNC, 0);
    send_word(32'hFFFE0001, 0);
    sb.push_back({1'b1, 1'b1, 32'hCAFEF00D});
    send_word(32'hCAFEF00D, 0);
    wait_drain("t2_drain");
    chk("t2_len", 64'(oLen), 64'd1);

    // Test 3: length 0 and MAX_WORDS+1 rejected, MAX_WORDS accepted
    restart();
    send_word(SYNC, 0);
    send_word(32'hFFFF0000, 0);
    exp_err++;
    cyc(2);
    chk("t3_len0_err", 64'(err_cnt), 64'(exp_err));
    chk("t3_len0_len", 64'(oLen), 64'd1);
    send_word(SYNC, 0);
    send_word(32'hFEFF0100, 0);
    exp_err++;
    cyc(2);
    chk("t3_len256_err", 64'(err_cnt), 64'(exp_err));
    chk("t3_nowrite", 64'(oValid), 64'd0);
    send_word(SYNC, 0);
    send_word(32'hFF0000FF, 0);
    for (int i = 0; i < 255; i++) begin
      w = pat(3, i);
      sb.push_back({(i == 0), (i == 254), w});
      send_word(w, 0);
    end
    wait_drain("t3_drain");
    chk("t3_len255", 64'(oLen), 64'd255);
    chk("t3_err", 64'(err_cnt), 64'(exp_err));

    // Test 4: consumer stalled, 10-word frame overflows the 8-entry FIFO
    iReady = 1'b0;
    restart();
    send_word(SYNC, 0);
    send_word(32'hFFF5000A, 0);
    for (int i = 0; i < 10; i++) begin
      w = pat(4, i);
      if (i < 8) sb.push_back({(i == 0), 1'b0, w});
      send_word(w, 0);
    end
    exp_err++;
    cyc(2);
    chk("t4_ovf", 64'(ovf_cnt), 64'd1);
    chk("t4_err", 64'(err_cnt), 64'(exp_err));
    chk("t4_len", 64'(oLen), 64'd10);
    chk("t4_head", 64'({oValid, oSof, oData}), 64'({1'b1, 1'b1, pat(4, 0)}));
    iReady = 1'b1;
    wait_drain("t4_drain");

    // Test 5: enable dropped mid-frame after 2 payload words
    iReady = 1'b0;
    restart();
    send_word(SYNC, 0);
    send_word(32'hFFFB0004, 0);
    for (int i = 0; i < 2; i++) begin
      w = pat(5, i);
      sb.push_back({(i == 0), 1'b0, w});
      send_word(w, 0);
    end
    send_bits(pat(5, 2), 10);
    iEnable = 1'b0;
    exp_err++;
    cyc(3);
    chk("t5_err", 64'(err_cnt), 64'(exp_err));
    chk("t5_busy", 64'(oBusy), 64'd0);
    chk("t5_valid", 64'(oValid), 64'd1);
    iReady = 1'b1;
    wait_drain("t5_drain");
    chk("t5_ovf", 64'(ovf_cnt), 64'd1);

    // Test 6: random bit gaps and a partial sync prefix before the real sync
    iEnable = 1'b1;
    cyc(1);
    send_bits(SYNC, 16);
    send_word(SYNC, 3);
    send_word(32'hFFFC0003, 3);
    for (int i = 0; i < 3; i++) begin
      w = pat(6, i) ^ 32'h5A5A0F0F;
      sb.push_back({(i == 0), (i == 2), w});
      send_word(w, 3);
    end
    wait_drain("t6_drain");
    chk("t6_len", 64'(oLen), 64'd3);
    chk("t6_err", 64'(err_cnt), 64'(exp_err));

    // Reset mid-frame clears everything including queued words
    iReady = 1'b0;
    restart();
    send_word(SYNC, 0);
    send_word(32'hFFFD0002, 0);
    send_word(32'h0BADBEEF, 0);
    chk("rst2_pre_valid", 64'(oValid), 64'd1);
    iReset_n = 1'b0;
    cyc(2);
    chk("rst2_valid", 64'(oValid), 64'd0);
    chk("rst2_data", 64'(oData), 64'd0);
    chk("rst2_len", 64'(oLen), 64'd0);
    chk("rst2_busy", 64'(oBusy), 64'd0);
    iReset_n = 1'b1;
    iReady = 1'b1;
    cyc(3);
    chk("rst2_empty", 64'(oValid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
